// File: rtl/pkt_fifo_pkg.sv
// Shared types and helpers for the packet FIFO: write-side state enum,
// default widths and modulo pointer difference.
package pkt_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;

  typedef enum logic {
    ST_ACCEPT  = 1'b0,
    ST_DISCARD = 1'b1
  } wr_state_e;

  // Difference a - b wrapped to aw+1 bits (pointer width incl. wrap bit).
  function automatic int unsigned ptr_diff(int unsigned a, int unsigned b, int aw);
    return (a - b) & ((32'd1 << (aw + 1)) - 32'd1);
  endfunction

endpackage

// File: rtl/pkt_fifo_mem.sv
// Dual-port word store {last, data}; read port is registered by default,
// asynchronous (head peek, zero while not valid) when FWFT_EN is defined.
module pkt_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
`ifndef FWFT_EN
  input  logic                  rst_i,
`endif
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH:0]   wdata_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH:0]   rdata_o,
  output logic                  head_last_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Last bit of the head word is needed combinationally for packet counting.
  assign head_last_o = mem_q[raddr_i][DATA_WIDTH];

`ifdef FWFT_EN
  assign rdata_o = rd_en_i ? mem_q[raddr_i] : '0;
`else
  logic [DATA_WIDTH:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)        rdata_q <= '0;
    else if (rd_en_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
`endif

endmodule

// File: rtl/pkt_fifo_sync.sv
// Packet FIFO: speculative write pointer, commit pointer, read pointer.
// States: ST_ACCEPT = storing words | ST_DISCARD = dropping rest of overflowed packet. FWFT_EN selects fall-through reads.
module pkt_fifo_sync
  import pkt_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int AFULL_MARGIN  = 2,
  parameter int AEMPTY_MARGIN = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  W_INC,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  W_LAST,
  input  logic                  W_DROP,
  output logic                  FULL,
  output logic                  ALMOST_FULL,
  input  logic                  R_INC,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  RD_LAST,
  output logic                  EMPTY,
  output logic                  ALMOST_EMPTY,
  output logic [ADDR_WIDTH:0]   OCCUPANCY,
  output logic [ADDR_WIDTH:0]   PKT_COUNT,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW,
  input  logic                  CLR_ERR
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;

  logic [PW-1:0] wr_q, wr_d, cm_q, cm_d, rd_q, rd_d, pkt_q, pkt_d;
  logic [PW-1:0] occ, cocc;
  wr_state_e     state_q, state_d;
  logic          ovf_q, ovf_d, udf_q, udf_d;
  logic          full, empty, do_wr, do_pop, commit, head_last;
  logic [DATA_WIDTH:0] rword;

  assign occ    = PW'(ptr_diff(32'(wr_q), 32'(rd_q), ADDR_WIDTH));
  assign cocc   = PW'(ptr_diff(32'(cm_q), 32'(rd_q), ADDR_WIDTH));
  assign full   = (occ == PW'(DEPTH));
  assign empty  = (cm_q == rd_q);
  assign do_pop = R_INC && !empty;

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    cm_d    = cm_q;
    do_wr   = 1'b0;
    commit  = 1'b0;
    if (W_DROP) begin
      wr_d    = cm_q;
      state_d = ST_ACCEPT;
    end else if (W_INC) begin
      if (full) begin
        // Overflowed packet is abandoned; skip its tail unless this was the tail.
        wr_d    = cm_q;
        state_d = W_LAST ? ST_ACCEPT : ST_DISCARD;
      end else begin
        unique case (state_q)
          ST_ACCEPT: begin
            do_wr = 1'b1;
            wr_d  = wr_q + 1'b1;
            if (W_LAST) begin
              cm_d   = wr_q + 1'b1;
              commit = 1'b1;
            end
          end
          ST_DISCARD: if (W_LAST) state_d = ST_ACCEPT;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_d  = do_pop ? rd_q + 1'b1 : rd_q;
    ovf_d = (ovf_q && !CLR_ERR) || (W_INC && full && !W_DROP);
    udf_d = (udf_q && !CLR_ERR) || (R_INC && empty);
    unique case ({commit, do_pop && head_last})
      2'b10:   pkt_d = pkt_q + 1'b1;
      2'b01:   pkt_d = pkt_q - 1'b1;
      default: pkt_d = pkt_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_ACCEPT;
      wr_q    <= '0;
      cm_q    <= '0;
      rd_q    <= '0;
      pkt_q   <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      cm_q    <= cm_d;
      rd_q    <= rd_d;
      pkt_q   <= pkt_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  pkt_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk_i      (CLK),
`ifndef FWFT_EN
    .rst_i      (RST),
    .rd_en_i    (do_pop),
`else
    .rd_en_i    (!empty),
`endif
    .we_i       (do_wr),
    .waddr_i    (wr_q[ADDR_WIDTH-1:0]),
    .wdata_i    ({W_LAST, WR_DATA}),
    .raddr_i    (rd_q[ADDR_WIDTH-1:0]),
    .rdata_o    (rword),
    .head_last_o(head_last)
  );

  assign FULL         = full;
  assign ALMOST_FULL  = (occ >= PW'(DEPTH - AFULL_MARGIN));
  assign EMPTY        = empty;
  assign ALMOST_EMPTY = (cocc <= PW'(AEMPTY_MARGIN));
  assign OCCUPANCY    = occ;
  assign PKT_COUNT    = pkt_q;
  assign OVERFLOW     = ovf_q;
  assign UNDERFLOW    = udf_q;
  assign RD_DATA      = rword[DATA_WIDTH-1:0];
  assign RD_LAST      = rword[DATA_WIDTH];

endmodule

// File: tb/tb_pkt_fifo_sync.sv
// Self-checking bench for pkt_fifo_sync: queue-based packet model, directed
// scenarios plus randomized traffic. Honors FWFT_EN like the design.
module tb_pkt_fifo_sync;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       W_INC = 1'b0, W_LAST = 1'b0, W_DROP = 1'b0, R_INC = 1'b0, CLR_ERR = 1'b0;
  logic [7:0] WR_DATA = '0;
  logic       FULL, ALMOST_FULL, EMPTY, ALMOST_EMPTY, RD_LAST, OVERFLOW, UNDERFLOW;
  logic [7:0] RD_DATA;
  logic [4:0] OCCUPANCY, PKT_COUNT;

  pkt_fifo_sync dut (
    .CLK(CLK), .RST(RST), .W_INC(W_INC), .WR_DATA(WR_DATA), .W_LAST(W_LAST),
    .W_DROP(W_DROP), .FULL(FULL), .ALMOST_FULL(ALMOST_FULL), .R_INC(R_INC),
    .RD_DATA(RD_DATA), .RD_LAST(RD_LAST), .EMPTY(EMPTY), .ALMOST_EMPTY(ALMOST_EMPTY),
    .OCCUPANCY(OCCUPANCY), .PKT_COUNT(PKT_COUNT), .OVERFLOW(OVERFLOW),
    .UNDERFLOW(UNDERFLOW), .CLR_ERR(CLR_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] d;
    bit         l;
  } word_t;

  word_t      qc[$];
  word_t      qu[$];
  bit         m_disc, m_ovf, m_udf, m_rlast;
  logic [7:0] m_rdata;
  int         n_chk = 0;
  int         n_fail = 0;

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(bit winc, logic [7:0] wd, bit wl, bit wdrop, bit rinc, bit clr, bit rst);
    int  occ;
    bit  full, empty, n_o, n_u;
    word_t w;
    if (rst) begin
      qc.delete(); qu.delete();
      m_disc = 0; m_ovf = 0; m_udf = 0; m_rdata = '0; m_rlast = 0;
      return;
    end
    occ   = qc.size() + qu.size();
    full  = (occ == 16);
    empty = (qc.size() == 0);
    n_u   = rinc && empty;
    n_o   = winc && full && !wdrop;
    if (rinc && !empty) begin
      w = qc.pop_front();
      m_rdata = w.d;
      m_rlast = w.l;
    end
    if (wdrop) begin
      qu.delete();
      m_disc = 0;
    end else if (winc) begin
      if (full) begin
        qu.delete();
        m_disc = !wl;
      end else if (m_disc) begin
        if (wl) m_disc = 0;
      end else begin
        w.d = wd;
        w.l = wl;
        qu.push_back(w);
        if (wl) begin
          foreach (qu[k]) qc.push_back(qu[k]);
          qu.delete();
        end
      end
    end
    m_ovf = (m_ovf && !clr) || n_o;
    m_udf = (m_udf && !clr) || n_u;
  endtask

  task automatic compare_all();
    int occ, cocc, pkts;
    logic [7:0] exp_d;
    bit exp_l;
    occ  = qc.size() + qu.size();
    cocc = qc.size();
    pkts = 0;
    foreach (qc[k]) if (qc[k].l) pkts++;
`ifdef FWFT_EN
    exp_d = (cocc != 0) ? qc[0].d : 8'h00;
    exp_l = (cocc != 0) ? qc[0].l : 1'b0;
`else
    exp_d = m_rdata;
    exp_l = m_rlast;
`endif
    chk("full",       int'(FULL),         int'(occ == 16));
    chk("almost_full", int'(ALMOST_FULL), int'(occ >= 14));
    chk("empty",      int'(EMPTY),        int'(cocc == 0));
    chk("almost_empty", int'(ALMOST_EMPTY), int'(cocc <= 2));
    chk("occupancy",  int'(OCCUPANCY),    occ);
    chk("pkt_count",  int'(PKT_COUNT),    pkts);
    chk("rd_data",    int'(RD_DATA),      int'(exp_d));
    chk("rd_last",    int'(RD_LAST),      int'(exp_l));
    chk("overflow",   int'(OVERFLOW),     int'(m_ovf));
    chk("underflow",  int'(UNDERFLOW),    int'(m_udf));
  endtask

  task automatic cyc(bit winc = 0, logic [7:0] wd = 8'h00, bit wl = 0, bit wdrop = 0,
                     bit rinc = 0, bit clr = 0, bit rst = 0);
    W_INC = winc; WR_DATA = wd; W_LAST = wl; W_DROP = wdrop;
    R_INC = rinc; CLR_ERR = clr; RST = rst;
    @(posedge CLK);
    model_step(winc, wd, wl, wdrop, rinc, clr, rst);
    #1;
    compare_all();
  endtask

  // One pop with a literal expectation on the popped word.
  task automatic read_expect(string name, logic [7:0] val, bit last);
`ifdef FWFT_EN
    chk(name, int'(RD_DATA), int'(val));
    chk({name, "_last"}, int'(RD_LAST), int'(last));
    cyc(.rinc(1));
`else
    cyc(.rinc(1));
    chk(name, int'(RD_DATA), int'(val));
    chk({name, "_last"}, int'(RD_LAST), int'(last));
`endif
  endtask

  initial begin
    int rp;
    // Reset
    cyc(.rst(1));
    cyc(.rst(1));
    chk("rst_empty", int'(EMPTY), 1);
    chk("rst_aempty", int'(ALMOST_EMPTY), 1);
    chk("rst_full", int'(FULL), 0);
    chk("rst_occ", int'(OCCUPANCY), 0);
    chk("rst_pkt", int'(PKT_COUNT), 0);
    chk("rst_rdata", int'(RD_DATA), 0);

    // Packet pass
    for (int i = 1; i <= 10; i++) begin
      cyc(.winc(1), .wd(8'(i)), .wl(i == 10));
      if (i == 9) chk("t2_empty_9", int'(EMPTY), 1);
    end
    chk("t2_empty_10", int'(EMPTY), 0);
    chk("t2_pkt", int'(PKT_COUNT), 1);
    for (int i = 1; i <= 10; i++) read_expect("t2_rd", 8'(i), i == 10);
    chk("t2_empty_end", int'(EMPTY), 1);
    chk("t2_pkt_end", int'(PKT_COUNT), 0);

    // Drop
    for (int i = 0; i < 4; i++) cyc(.winc(1), .wd(8'h11 + 8'(i)));
    cyc(.wdrop(1));
    chk("t3_occ", int'(OCCUPANCY), 0);
    chk("t3_empty", int'(EMPTY), 1);
    cyc(.winc(1), .wd(8'hA1));
    cyc(.winc(1), .wd(8'hA2));
    cyc(.winc(1), .wd(8'hA3), .wl(1));
    read_expect("t3_rd0", 8'hA1, 0);
    read_expect("t3_rd1", 8'hA2, 0);
    read_expect("t3_rd2", 8'hA3, 1);

    // Overflow
    for (int i = 1; i <= 20; i++) begin
      cyc(.winc(1), .wd(8'h40 + 8'(i)), .wl(i == 20));
      if (i == 15) chk("t4_full_15", int'(FULL), 0);
      if (i == 16) chk("t4_full_16", int'(FULL), 1);
      if (i == 17) begin
        chk("t4_ovf", int'(OVERFLOW), 1);
        chk("t4_occ17", int'(OCCUPANCY), 0);
      end
    end
    chk("t4_occ20", int'(OCCUPANCY), 0);
    chk("t4_pkt20", int'(PKT_COUNT), 0);
    cyc(.winc(1), .wd(8'h55));
    cyc(.winc(1), .wd(8'h56), .wl(1));
    chk("t4_pkt_commit", int'(PKT_COUNT), 1);
    cyc(.clr(1));
    chk("t4_clr", int'(OVERFLOW), 0);
    read_expect("t4_rd0", 8'h55, 0);
    read_expect("t4_rd1", 8'h56, 1);

    // Concurrency and wrap
    for (int i = 0; i < 40; i++) begin
      cyc(.winc(1), .wd(8'(i + 1)), .wl((i % 10) == 9), .rinc(i >= 10));
      if (i == 19) chk("t5_pkt_same", int'(PKT_COUNT), 1);
    end
    for (int i = 31; i <= 40; i++) read_expect("t5_tail", 8'(i), i == 40);

    // Underflow
    cyc(.rinc(1));
    chk("t6_udf", int'(UNDERFLOW), 1);
`ifdef FWFT_EN
    chk("t6_rdata", int'(RD_DATA), 0);
`else
    chk("t6_rdata", int'(RD_DATA), 8'h28);
`endif
    cyc();
    cyc();
    chk("t6_udf_hold", int'(UNDERFLOW), 1);
    cyc(.clr(1));
    chk("t6_clr", int'(UNDERFLOW), 0);

    // Randomized traffic, alternating read-light and read-heavy phases
    for (int i = 0; i < 3000; i++) begin
      rp = ((i / 200) % 2 == 0) ? 25 : 80;
      cyc(.winc($urandom_range(99) < 60),
          .wd(8'($urandom)),
          .wl($urandom_range(99) < 20),
          .wdrop($urandom_range(99) < 3),
          .rinc($urandom_range(99) < rp),
          .clr($urandom_range(99) < 5),
          .rst($urandom_range(999) < 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
